// File: rtl/cnn_job_scheduler.sv
// cnn_job_scheduler
//
// Runs one convolution job at a time through the CNN top: latches the job
// configuration, fills the filter buffer from system memory, pulses
// cnn_start, then streams IFmap words into the IFmap buffer while the result
// buffer is drained back to memory.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   job_*                      job request handshake and configuration
//   mem_rd_*                   memory read port (data returns one cycle later)
//   mem_wr_*                   memory write port
//   cnn_start/stride/...       start pulse and held configuration to the CNN
//   IFmap_buffer_*             IFmap buffer write side
//   filter_buffer_*            filter buffer write side
//   result_buffer_*            result buffer read side
//   stall_signal               CNN stall indication (counted during STREAM)
//   busy, job_done             status; job_done is a one-cycle pulse
//   stall_cycles               saturating stall count of the current/last job
//
// States
//   state  | meaning
//   IDLE   | waiting for a job; job_ready high
//   LOAD_F | copying job_f_len words from memory into the filter buffer
//   KICK   | one-cycle cnn_start pulse
//   STREAM | IFmap words to the IFmap buffer, results back to memory
//   DONE   | one-cycle job_done pulse

module cnn_job_scheduler #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 16,
  parameter int LEN_WIDTH         = 16,
  parameter int STRIDE_WIDTH      = 8,
  parameter int FILTER_SIZE_WIDTH = 8,
  parameter int STALL_CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [ADDR_WIDTH-1:0]        job_if_base,
  input  logic [ADDR_WIDTH-1:0]        job_f_base,
  input  logic [ADDR_WIDTH-1:0]        job_res_base,
  input  logic [LEN_WIDTH-1:0]         job_if_len,
  input  logic [LEN_WIDTH-1:0]         job_f_len,
  input  logic [LEN_WIDTH-1:0]         job_res_len,
  input  logic [STRIDE_WIDTH-1:0]      job_stride,
  input  logic [FILTER_SIZE_WIDTH-1:0] job_filter_size,
  input  logic                         job_psum_mode,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic                         mem_wr_en,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr,
  output logic [DATA_WIDTH-1:0]        mem_wr_data,
  output logic                         cnn_start,
  output logic [STRIDE_WIDTH-1:0]      cnn_stride,
  output logic [FILTER_SIZE_WIDTH-1:0] cnn_filter_size,
  output logic                         cnn_psum_mode,
  output logic [DATA_WIDTH-1:0]        IFmap_buffer_in,
  output logic                         IFmap_buffer_write_enable,
  input  logic                         IFmap_buffer_full,
  output logic [DATA_WIDTH-1:0]        filter_buffer_in,
  output logic                         filter_buffer_write_enable,
  input  logic                         filter_buffer_full,
  input  logic [DATA_WIDTH-1:0]        result_buffer_out,
  input  logic                         result_buffer_empty,
  input  logic                         result_buffer_valid,
  output logic                         result_buffer_read_enable,
  input  logic                         stall_signal,
  output logic                         busy,
  output logic                         job_done,
  output logic [STALL_CNT_WIDTH-1:0]   stall_cycles
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_F = 3'd1,
    KICK   = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_nxt;

  // latched job configuration
  logic [ADDR_WIDTH-1:0]        if_base_q, f_base_q, res_base_q;
  logic [LEN_WIDTH-1:0]         if_len_q, f_len_q, res_len_q;
  logic [STRIDE_WIDTH-1:0]      stride_q;
  logic [FILTER_SIZE_WIDTH-1:0] filter_size_q;
  logic                         psum_mode_q;

  // shared read path (filter in LOAD_F, IFmap in STREAM)
  logic [LEN_WIDTH-1:0]  rd_issued, rd_written;
  logic                  rd_inflight;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;

  // result drain
  logic [LEN_WIDTH-1:0]  res_requested, res_captured;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;

  logic [STALL_CNT_WIDTH-1:0] stall_q;

  // read path combinational terms
  logic                  rd_phase;
  logic                  tgt_full;
  logic [ADDR_WIDTH-1:0] tgt_base;
  logic [LEN_WIDTH-1:0]  tgt_len;
  logic                  rd_go;
  logic                  tgt_wr;
  logic                  skid_load;
  logic [DATA_WIDTH-1:0] tgt_word;
  logic [LEN_WIDTH-1:0]  written_nxt;
  logic                  accept;
  logic                  res_rd;
  logic                  res_capture;

  always_comb begin
    rd_phase    = (state == LOAD_F) || (state == STREAM);
    tgt_full    = (state == LOAD_F) ? filter_buffer_full : IFmap_buffer_full;
    tgt_base    = (state == LOAD_F) ? f_base_q : if_base_q;
    tgt_len     = (state == LOAD_F) ? f_len_q : if_len_q;
    // skid_valid blocks issue so the skid can never be asked to hold two words
    rd_go       = rd_phase && (rd_issued < tgt_len) && !tgt_full && !skid_valid;
    // a skid word and a returning word are never present together: a word is
    // parked only when the target is full, and no read is issued while full
    tgt_wr      = rd_phase && !tgt_full && (skid_valid || rd_inflight);
    skid_load   = rd_phase && tgt_full && rd_inflight;
    tgt_word    = skid_valid ? skid_data : mem_rd_data;
    written_nxt = rd_written + LEN_WIDTH'(tgt_wr);
    accept      = (state == IDLE) && job_valid;
    res_rd      = (state == STREAM) && !result_buffer_empty && (res_requested < res_len_q);
    res_capture = (state == STREAM) && result_buffer_valid && (res_captured < res_len_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (job_valid) begin
          state_nxt = (job_f_len == '0) ? KICK : LOAD_F;
        end
      end
      LOAD_F: begin
        if (written_nxt == f_len_q) begin
          state_nxt = KICK;
        end
      end
      KICK: begin
        state_nxt = STREAM;
      end
      STREAM: begin
        // last result capture sets res_captured; its memory write is issued
        // from the registered port in the same cycle this condition holds
        if ((written_nxt == if_len_q) && !skid_load && (res_captured == res_len_q)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_base_q     <= '0;
      f_base_q      <= '0;
      res_base_q    <= '0;
      if_len_q      <= '0;
      f_len_q       <= '0;
      res_len_q     <= '0;
      stride_q      <= '0;
      filter_size_q <= '0;
      psum_mode_q   <= 1'b0;
      rd_issued     <= '0;
      rd_written    <= '0;
      rd_inflight   <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      res_requested <= '0;
      res_captured  <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      stall_q       <= '0;
    end else begin
      rd_inflight <= rd_go;
      wr_en_q     <= 1'b0;

      if (accept) begin
        if_base_q     <= job_if_base;
        f_base_q      <= job_f_base;
        res_base_q    <= job_res_base;
        if_len_q      <= job_if_len;
        f_len_q       <= job_f_len;
        res_len_q     <= job_res_len;
        stride_q      <= job_stride;
        filter_size_q <= job_filter_size;
        psum_mode_q   <= job_psum_mode;
        rd_issued     <= '0;
        rd_written    <= '0;
        skid_valid    <= 1'b0;
        res_requested <= '0;
        res_captured  <= '0;
        stall_q       <= '0;
      end else if (state == KICK) begin
        // the read path is reused for the IFmap phase
        rd_issued  <= '0;
        rd_written <= '0;
      end else if (rd_phase) begin
        if (rd_go) begin
          rd_issued <= rd_issued + 1'b1;
        end
        rd_written <= written_nxt;
        if (skid_load) begin
          skid_valid <= 1'b1;
          skid_data  <= mem_rd_data;
        end else if (skid_valid && !tgt_full) begin
          skid_valid <= 1'b0;
        end
      end

      if (res_rd) begin
        res_requested <= res_requested + 1'b1;
      end
      if (res_capture) begin
        wr_en_q      <= 1'b1;
        wr_addr_q    <= res_base_q + ADDR_WIDTH'(res_captured);
        wr_data_q    <= result_buffer_out;
        res_captured <= res_captured + 1'b1;
      end

      if ((state == STREAM) && stall_signal && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign job_ready                  = (state == IDLE);
  assign busy                       = (state != IDLE);
  assign cnn_start                  = (state == KICK);
  assign job_done                   = (state == DONE);
  assign cnn_stride                 = stride_q;
  assign cnn_filter_size            = filter_size_q;
  assign cnn_psum_mode              = psum_mode_q;
  assign mem_rd_en                  = rd_go;
  assign mem_rd_addr                = tgt_base + ADDR_WIDTH'(rd_issued);
  assign mem_wr_en                  = wr_en_q;
  assign mem_wr_addr                = wr_addr_q;
  assign mem_wr_data                = wr_data_q;
  assign filter_buffer_write_enable = (state == LOAD_F) && tgt_wr;
  assign filter_buffer_in           = (state == LOAD_F) ? tgt_word : '0;
  assign IFmap_buffer_write_enable  = (state == STREAM) && tgt_wr;
  assign IFmap_buffer_in            = (state == STREAM) ? tgt_word : '0;
  assign result_buffer_read_enable  = res_rd;
  assign stall_cycles               = stall_q;

endmodule
